// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encodings and log2 helper for pc_sequencer
package pc_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_HALT = 2'd2;

    // Smallest r with 2**r >= v; STEP is a power of two, so this is exact.
    function automatic int unsigned log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - word-aligned fetch address generator with stall, redirect and wrap/halt
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int          ADDR_W = 32,
    parameter int unsigned STEP   = 4,
    parameter int unsigned START  = 0,
    parameter int unsigned LAST   = 60,
    parameter int          WRAP   = 0,
    parameter int          CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [ADDR_W-1:0] Addr_o,
    output logic              addr_valid,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  fetch_cnt
);

    localparam int unsigned       LSB     = log2(STEP);
    localparam logic [ADDR_W-1:0] A_START = ADDR_W'(START);
    localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(LAST);
    localparam logic [ADDR_W-1:0] A_STEP  = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] A_SPAN  = A_LAST - A_START;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;
    logic              r_done;
    logic              r_err;

    logic [ADDR_W-1:0] w_target;
    logic              w_in_range;
    logic              w_clr;
    logic              w_inc;

    assign w_target = (ld_addr >> LSB) << LSB;
    // Offset trick folds both bounds into one unsigned compare (LAST >= START).
    assign w_in_range = (w_target - A_START) <= A_SPAN;
    assign w_clr      = (r_state != ST_RUN) && start;
    assign w_inc      = (r_state == ST_RUN) && r_valid && !stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= A_START;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_addr  <= A_START;
                        r_valid <= 1'b1;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (ld_en) begin
                        if (w_in_range) begin
                            r_addr <= w_target;
                        end else begin
                            r_err <= 1'b1;
                            if (WRAP != 0) begin
                                r_addr <= A_START;
                            end else begin
                                r_state <= ST_HALT;
                                r_valid <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end else if (!stall) begin
                        if (r_addr == A_LAST) begin
                            if (WRAP != 0) begin
                                r_addr <= A_START;
                            end else begin
                                r_state <= ST_HALT;
                                r_valid <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_addr <= r_addr + A_STEP;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_fetch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .inc   (w_inc),
        .q     (fetch_cnt)
    );

    assign Addr_o     = r_addr;
    assign addr_valid = r_valid;
    assign done       = r_done;
    assign err        = r_err;

endmodule
